// File: rtl/store_unit_pkg.sv
// Shared types, widths and byte-select helper for the 16-bit register store unit.
package store_unit_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 2 * BYTE_W;
  localparam int unsigned DEFAULT_DATA_W = WORD_W;
  localparam int unsigned DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Returns the high half of the word when hi is set, otherwise the low half.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                 input logic              hi);
    return hi ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/store_addr_counter.sv
// Byte address register for the store unit: load on start, increment after the first byte.
module store_addr_counter #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  // Load wins over increment; increment wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/reg16_store_unit.sv
// Stores a captured 16-bit register word to byte-wide memory as two handshaked writes.
// Define STORE_BIG_ENDIAN_EN to write the high byte to the base address.
module reg16_store_unit #(
  parameter int unsigned DATA_W = store_unit_pkg::DEFAULT_DATA_W,
  parameter int unsigned BYTE_W = store_unit_pkg::BYTE_W,
  parameter int unsigned ADDR_W = store_unit_pkg::DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  import store_unit_pkg::*;

`ifdef STORE_BIG_ENDIAN_EN
  localparam bit FIRST_HI = 1'b1;
`else
  localparam bit FIRST_HI = 1'b0;
`endif

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_n;
  logic [BYTE_W-1:0] data_n;
  logic              we_n;
  logic              busy_n;
  logic              done_n;
  logic              addr_load;
  logic              addr_inc;

  store_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .inc      (addr_inc),
    .load_val (addr_i),
    .count    (mem_addr)
  );

  // State and registered outputs; outputs are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      word_q   <= '0;
      mem_we   <= 1'b0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      word_q   <= word_n;
      mem_we   <= we_n;
      mem_data <= data_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state and next-output decode; mem_we is only ever high in WR_LO/WR_HI.
  always_comb begin
    state_n   = state;
    word_n    = word_q;
    we_n      = mem_we;
    data_n    = mem_data;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = WR_LO;
          word_n    = data_i;
          we_n      = 1'b1;
          data_n    = BYTE_W'(byte_sel(WORD_W'(data_i), FIRST_HI));
          addr_load = 1'b1;
        end
      end
      WR_LO: begin
        if (mem_ready) begin
          state_n  = WR_HI;
          data_n   = BYTE_W'(byte_sel(WORD_W'(word_q), !FIRST_HI));
          addr_inc = 1'b1;
        end
      end
      WR_HI: begin
        if (mem_ready) begin
          state_n = DONE;
          we_n    = 1'b0;
        end
      end
      DONE: begin
        state_n = IDLE;
        we_n    = 1'b0;
      end
      default: begin
        state_n = IDLE;
        we_n    = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_reg16_store_unit.sv
// Scoreboard bench for reg16_store_unit: expected byte writes queued at start, popped on handshake.
module tb_reg16_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data_i;
  logic [15:0] addr_i;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        busy;
  logic        done;

  logic [23:0] sb_q[$];
  int          n_checks;
  int          n_pass;

`ifdef STORE_BIG_ENDIAN_EN
  localparam bit BIG = 1'b1;
`else
  localparam bit BIG = 1'b0;
`endif

  reg16_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit ready_at(input int c, input int lo, input int hi);
    return !((c <= lo) || ((c >= lo + 2) && (c <= lo + 1 + hi)));
  endfunction

  // Memory-side monitor: a write is accepted at the next rising edge when we and ready are both high.
  always @(negedge clk) begin
    if (rst && mem_we && mem_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {8'h0, mem_addr, mem_data}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[23:8]));
        check("wr_data", 32'(mem_data), 32'(e[7:0]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One store with lo/hi stall cycles; poke issues an ignored start during WR_HI.
  task automatic run_store(input logic [15:0] d, input logic [15:0] a,
                           input int lo, input int hi, input bit poke);
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] a1;
    int          c;
    int          lat;
    bit          seen;
    b0  = BIG ? d[15:8] : d[7:0];
    b1  = BIG ? d[7:0]  : d[15:8];
    a1  = a + 16'd1;
    lat = lo + hi + 3;
    sb_q.push_back({a, b0});
    sb_q.push_back({a1, b1});
    start     = 1'b1;
    data_i    = d;
    addr_i    = a;
    mem_ready = 1'b0;
    tick();
    start  = 1'b0;
    data_i = ~d;
    addr_i = ~a;
    c      = 1;
    seen   = 1'b0;
    while (!seen && c <= 40) begin
      mem_ready = ready_at(c, lo, hi);
      if (poke && c == 2) begin
        start  = 1'b1;
        data_i = 16'hBEEF;
      end else begin
        start = 1'b0;
      end
      check("busy_during", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        check("we_in_done", 32'(mem_we), 32'd0);
      end else begin
        check("we_held", 32'(mem_we), 32'd1);
        check("addr_held", 32'(mem_addr), (c <= lo + 1) ? 32'(a) : 32'(a1));
        check("data_held", 32'(mem_data), (c <= lo + 1) ? 32'(b0) : 32'(b1));
        tick();
        c++;
      end
    end
    check("latency", 32'(c), 32'(lat));
    start     = 1'b0;
    mem_ready = 1'b0;
    tick();
    check("done_once", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("we_after", 32'(mem_we), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    start     = 1'b0;
    data_i    = 16'h0;
    addr_i    = 16'h0;
    mem_ready = 1'b0;
    tick();
    tick();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();

    // Basic, backpressure, wrap-around
    run_store(16'hA5C3, 16'h0040, 0, 0, 1'b0);
    run_store(16'h5A3C, 16'h1230, 2, 1, 1'b0);
    run_store(16'h1234, 16'hFFFF, 0, 0, 1'b0);

    // Start ignored while busy, then the next start is accepted
    run_store(16'h0F1E, 16'h0200, 0, 0, 1'b1);
    run_store(16'hBEEF, 16'h0300, 0, 0, 1'b0);

    // Reset right after the low byte is accepted
    sb_q.push_back({16'h0500, BIG ? 8'h77 : 8'h88});
    start     = 1'b1;
    data_i    = 16'h7788;
    addr_i    = 16'h0500;
    mem_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst       = 1'b0;
    mem_ready = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_data", 32'(mem_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    check("abort_idle_busy", 32'(busy), 32'd0);
    mem_ready = 1'b0;
    run_store(16'hCAFE, 16'h0600, 1, 0, 1'b0);

    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
